// File: rtl/phase_wrap_ctrl_if.sv
// Bundle for the phase_wrap_ctrl configuration handshake, the increment
// stream and the wrapped-phase result stream. Signal suffixes are seen
// from the controller, which connects through the slave modport.
interface phase_wrap_ctrl_if #(
  parameter int WIDTH     = 14,
  parameter int CNT_WIDTH = 16
);
  logic                        cfg_valid_i;
  logic                        cfg_ready_o;
  logic signed [WIDTH:0]       lower_i;
  logic signed [WIDTH:0]       upper_i;
  logic                        data_valid_i;
  logic signed [WIDTH-1:0]     data_i;
  logic signed [WIDTH:0]       phase_o;
  logic                        valid_o;
  logic                        wrap_up_o;
  logic                        wrap_dn_o;
  logic signed [CNT_WIDTH-1:0] wrap_cnt_o;

  modport master (
    output cfg_valid_i, lower_i, upper_i, data_valid_i, data_i,
    input  cfg_ready_o, phase_o, valid_o, wrap_up_o, wrap_dn_o, wrap_cnt_o
  );

  modport slave (
    input  cfg_valid_i, lower_i, upper_i, data_valid_i, data_i,
    output cfg_ready_o, phase_o, valid_o, wrap_up_o, wrap_dn_o, wrap_cnt_o
  );
endinterface

// File: rtl/phase_wrap_ctrl.sv
// Phase accumulator that wraps into an inclusive [lower, upper] window and
// keeps a saturating signed count of net wraps (up minus down). Bounds are
// taken through a ready/valid handshake while idle; a bad window parks the
// controller in ERR until clear_i.
module phase_wrap_ctrl #(
  parameter int WIDTH     = 14,
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              clear_i,
  phase_wrap_ctrl_if.slave  bus,
  output logic              busy_o,
  output logic              err_o
);

  // Datapath is three bits wider than the phase: the span of a full-range
  // window needs WIDTH+2 magnitude bits, and the corrected value may then
  // sit a further span outside the window before it is clamped.
  localparam int EXT = WIDTH + 3;

  localparam logic signed [CNT_WIDTH-1:0] CNT_MAX   = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic signed [CNT_WIDTH-1:0] CNT_MIN   = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic signed [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic signed [WIDTH:0]       UPPER_RST = {1'b0, {WIDTH{1'b1}}};
  localparam logic signed [EXT-1:0]       EXT_ONE   = EXT'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ERR
  } state_t;

  state_t                      state_q, state_d;
  logic signed [WIDTH:0]       lower_q, lower_d;
  logic signed [WIDTH:0]       upper_q, upper_d;
  logic signed [WIDTH:0]       phase_q, phase_d;
  logic signed [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                        valid_q, valid_d;
  logic                        up_q, up_d;
  logic                        dn_q, dn_d;
  logic                        err_q, err_d;

  logic signed [EXT-1:0]       lowerX, upperX, phaseX, dataX;
  logic signed [EXT-1:0]       sumX, spanX, wrapped;
  logic signed [WIDTH:0]       wrapPhase;
  logic                        wrapUp, wrapDn, wrapErr;
  logic signed [CNT_WIDTH-1:0] cntInc, cntDec;

  // Wrap datapath: add the increment, fold back by one span on overflow of
  // either bound, and clamp if a single fold is not enough.
  always_comb begin
    lowerX  = {{2{lower_q[WIDTH]}}, lower_q};
    upperX  = {{2{upper_q[WIDTH]}}, upper_q};
    phaseX  = {{2{phase_q[WIDTH]}}, phase_q};
    dataX   = {{3{bus.data_i[WIDTH-1]}}, bus.data_i};
    sumX    = phaseX + dataX;
    spanX   = upperX - lowerX + EXT_ONE;
    wrapped = sumX;
    wrapUp  = 1'b0;
    wrapDn  = 1'b0;
    wrapErr = 1'b0;
    if (sumX > upperX) begin
      wrapUp  = 1'b1;
      wrapped = sumX - spanX;
      if (wrapped > upperX) begin
        wrapped = upperX;
        wrapErr = 1'b1;
      end
    end else if (sumX < lowerX) begin
      wrapDn  = 1'b1;
      wrapped = sumX + spanX;
      if (wrapped < lowerX) begin
        wrapped = lowerX;
        wrapErr = 1'b1;
      end
    end
    wrapPhase = wrapped[WIDTH:0];
  end

  // Saturating neighbours of the wrap counter; it never rolls over.
  always_comb begin
    cntInc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    cntDec = (cnt_q == CNT_MIN) ? cnt_q : cnt_q - CNT_ONE;
  end

  // Controller next state: stop beats clear beats data in RUN, stop beats
  // start in IDLE, and ERR is only left through clear.
  always_comb begin
    state_d = state_q;
    lower_d = lower_q;
    upper_d = upper_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.cfg_valid_i) begin
          if (bus.upper_i <= bus.lower_i) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            lower_d = bus.lower_i;
            upper_d = bus.upper_i;
          end
        end
        if (state_d == IDLE && start_i && !stop_i && (upper_q > lower_q)) begin
          phase_d = lower_q;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (clear_i) begin
          phase_d = lower_q;
          cnt_d   = '0;
        end else if (bus.data_valid_i) begin
          phase_d = wrapPhase;
          valid_d = 1'b1;
          up_d    = wrapUp;
          dn_d    = wrapDn;
          if (wrapErr) begin
            err_d = 1'b1;
          end
          if (wrapUp) begin
            cnt_d = cntInc;
          end else if (wrapDn) begin
            cnt_d = cntDec;
          end
        end
      end
      ERR: begin
        if (clear_i) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset to a full-range window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lower_q <= '0;
      upper_q <= UPPER_RST;
      phase_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lower_q <= lower_d;
      upper_q <= upper_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      err_q   <= err_d;
    end
  end

  assign bus.cfg_ready_o = (state_q == IDLE);
  assign bus.phase_o     = phase_q;
  assign bus.valid_o     = valid_q;
  assign bus.wrap_up_o   = up_q;
  assign bus.wrap_dn_o   = dn_q;
  assign bus.wrap_cnt_o  = cnt_q;
  assign busy_o          = (state_q == RUN);
  assign err_o           = err_q;

endmodule

// File: tb/tb_phase_wrap_ctrl.sv
// Directed bench for phase_wrap_ctrl with a 4-bit wrap counter so that
// saturation is reachable in a few beats. Every data beat pushes its
// expected result; the result is popped one cycle later when valid_o shows.
module tb_phase_wrap_ctrl;

  localparam int TW   = 14;
  localparam int CW   = 4;
  localparam int CMAX = 7;
  localparam int CMIN = -8;

  typedef struct {
    int phase;
    int cnt;
    bit up;
    bit dn;
  } exp_t;

  logic clk_i;
  logic rst_i;
  logic start_i;
  logic stop_i;
  logic clear_i;
  logic busy_o;
  logic err_o;

  int   checks;
  int   failures;
  exp_t sbQ[$];

  int   mPhase;
  int   mCnt;
  int   mLo;
  int   mHi;
  bit   mErr;

  phase_wrap_ctrl_if #(.WIDTH(TW), .CNT_WIDTH(CW)) bus ();

  phase_wrap_ctrl #(.WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .stop_i  (stop_i),
    .clear_i (clear_i),
    .bus     (bus),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  // Free-running 10 ns clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Fixed one-cycle latency: valid_o must be high exactly when an
  // expectation is queued, and the popped entry must match.
  task automatic monitor();
    exp_t e;
    checkOutput("valid", bus.valid_o, (sbQ.size() > 0) ? 1 : 0);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("sb_phase", bus.phase_o, e.phase);
      checkOutput("sb_cnt", bus.wrap_cnt_o, e.cnt);
      checkOutput("sb_up", bus.wrap_up_o, e.up);
      checkOutput("sb_dn", bus.wrap_dn_o, e.dn);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input bit cl,
                               input bit cv, input int lo, input int hi,
                               input bit dv, input int d);
    start_i          = st;
    stop_i           = sp;
    clear_i          = cl;
    bus.cfg_valid_i  = cv;
    bus.lower_i      = lo[TW:0];
    bus.upper_i      = hi[TW:0];
    bus.data_valid_i = dv;
    bus.data_i       = d[TW-1:0];
    @(posedge clk_i);
    #1;
    monitor();
    start_i          = 1'b0;
    stop_i           = 1'b0;
    clear_i          = 1'b0;
    bus.cfg_valid_i  = 1'b0;
    bus.data_valid_i = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doStart();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    mPhase = mLo;
    mCnt   = 0;
    checkOutput("start_busy", busy_o, 1);
    checkOutput("start_phase", bus.phase_o, mLo);
    checkOutput("start_cnt", bus.wrap_cnt_o, 0);
  endtask

  task automatic doStop();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("stop_busy", busy_o, 0);
  endtask

  task automatic doConfig(input int lo, input int hi);
    applyStimulus(0, 0, 0, 1, lo, hi, 0, 0);
    if (hi > lo) begin
      mLo = lo;
      mHi = hi;
    end else begin
      mErr = 1'b1;
    end
  endtask

  // Reference wrap rule written directly from the window definition.
  task automatic sendData(input int d);
    exp_t e;
    int sum;
    int span;
    sum   = mPhase + d;
    span  = mHi - mLo + 1;
    e.up  = 1'b0;
    e.dn  = 1'b0;
    e.phase = sum;
    if (sum > mHi) begin
      e.up    = 1'b1;
      e.phase = sum - span;
      if (e.phase > mHi) begin
        e.phase = mHi;
        mErr    = 1'b1;
      end
    end else if (sum < mLo) begin
      e.dn    = 1'b1;
      e.phase = sum + span;
      if (e.phase < mLo) begin
        e.phase = mLo;
        mErr    = 1'b1;
      end
    end
    if (e.up && mCnt < CMAX) mCnt++;
    if (e.dn && mCnt > CMIN) mCnt--;
    mPhase = e.phase;
    e.cnt  = mCnt;
    sbQ.push_back(e);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, d);
    checkOutput("data_err", err_o, mErr);
    checkOutput("data_busy", busy_o, 1);
  endtask

  task automatic doReset(input bit withData);
    rst_i            = 1'b1;
    bus.data_valid_i = withData;
    bus.data_i       = 14'sd10;
    @(posedge clk_i);
    #1;
    monitor();
    rst_i            = 1'b0;
    bus.data_valid_i = 1'b0;
    mPhase = 0;
    mCnt   = 0;
    mLo    = 0;
    mHi    = 16383;
    mErr   = 1'b0;
    checkOutput("rst_phase", bus.phase_o, 0);
    checkOutput("rst_cnt", bus.wrap_cnt_o, 0);
    checkOutput("rst_valid", bus.valid_o, 0);
    checkOutput("rst_up", bus.wrap_up_o, 0);
    checkOutput("rst_dn", bus.wrap_dn_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_cfg_ready", bus.cfg_ready_o, 1);
  endtask

  // Directed sequence covering wraps, clamps, priorities, errors and reset.
  initial begin
    checks           = 0;
    failures         = 0;
    rst_i            = 1'b1;
    start_i          = 1'b0;
    stop_i           = 1'b0;
    clear_i          = 1'b0;
    bus.cfg_valid_i  = 1'b0;
    bus.lower_i      = '0;
    bus.upper_i      = '0;
    bus.data_valid_i = 1'b0;
    bus.data_i       = '0;

    $display("[TB] reset");
    doReset(0);

    $display("[TB] up-wrap on default window");
    doStart();
    checkOutput("run_cfg_ready", bus.cfg_ready_o, 0);
    for (int i = 0; i < 16; i++) sendData(1000);
    checkOutput("phase_16000", bus.phase_o, 16000);
    sendData(1000);
    checkOutput("upwrap_phase", bus.phase_o, 616);
    checkOutput("upwrap_pulse", bus.wrap_up_o, 1);
    checkOutput("upwrap_cnt", bus.wrap_cnt_o, 1);
    idleCycle();
    checkOutput("upwrap_pulse_end", bus.wrap_up_o, 0);
    doStop();
    checkOutput("stop_phase_hold", bus.phase_o, 616);
    checkOutput("stop_cnt_hold", bus.wrap_cnt_o, 1);
    checkOutput("idle_cfg_ready", bus.cfg_ready_o, 1);

    $display("[TB] down-wrap on -100..99");
    doConfig(-100, 99);
    checkOutput("cfg_ok_err", err_o, 0);
    doStart();
    sendData(10);
    sendData(-20);
    checkOutput("dnwrap_phase", bus.phase_o, 90);
    checkOutput("dnwrap_pulse", bus.wrap_dn_o, 1);
    checkOutput("dnwrap_cnt", bus.wrap_cnt_o, -1);

    $display("[TB] clear in RUN overrides data");
    sendData(-150);
    sendData(-60);
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 10);
    mPhase = mLo;
    mCnt   = 0;
    checkOutput("clear_phase", bus.phase_o, -100);
    checkOutput("clear_cnt", bus.wrap_cnt_o, 0);
    checkOutput("clear_busy", busy_o, 1);

    $display("[TB] start ignored in RUN");
    sendData(30);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("run_start_phase", bus.phase_o, -70);
    checkOutput("run_start_busy", busy_o, 1);

    $display("[TB] stop beats clear and data");
    sendData(-40);
    applyStimulus(0, 1, 1, 0, 0, 0, 1, 10);
    checkOutput("stopall_busy", busy_o, 0);
    checkOutput("stopall_phase", bus.phase_o, 90);
    checkOutput("stopall_cnt", bus.wrap_cnt_o, -1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("startstop_busy", busy_o, 0);
    checkOutput("startstop_phase", bus.phase_o, 90);

    $display("[TB] clamp on 0..9");
    doConfig(0, 9);
    doStart();
    sendData(25);
    checkOutput("clamp_phase", bus.phase_o, 9);
    checkOutput("clamp_err", err_o, 1);
    checkOutput("clamp_busy", busy_o, 1);
    sendData(3);
    sendData(-13);
    checkOutput("clamp_lo_phase", bus.phase_o, 0);
    doStop();

    $display("[TB] bad config parks in ERR");
    doReset(0);
    doConfig(50, 50);
    checkOutput("err_flag", err_o, 1);
    checkOutput("err_cfg_ready", bus.cfg_ready_o, 0);
    checkOutput("err_busy", busy_o, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("err_start_busy", busy_o, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    mErr = 1'b0;
    checkOutput("err_clear_err", err_o, 0);
    checkOutput("err_clear_ready", bus.cfg_ready_o, 1);
    doStart();
    sendData(60);
    checkOutput("bounds_kept", bus.phase_o, 60);
    doStop();

    $display("[TB] counter saturation and mid-RUN reset");
    doConfig(0, 9);
    doStart();
    for (int i = 0; i < 8; i++) sendData(10);
    checkOutput("sat_hi", bus.wrap_cnt_o, 7);
    for (int i = 0; i < 16; i++) sendData(-10);
    checkOutput("sat_lo", bus.wrap_cnt_o, -8);
    doReset(1);
    doStart();
    sendData(10);
    checkOutput("rst_window_phase", bus.phase_o, 10);
    checkOutput("rst_window_up", bus.wrap_up_o, 0);

    checkOutput("sb_empty", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_wrap_ctrl.md
PHASE_WRAP_CTRL -- requirements
Module: phase_wrap_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 14: width of the signed phase increment data_i.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the signed net wrap counter.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1: single-cycle pulse that starts accumulation.
REQ-006 SHALL have port stop_i, input, 1: single-cycle pulse that stops accumulation.
REQ-007 SHALL have port clear_i, input, 1: single-cycle pulse that re-initialises phase and counter.
REQ-008 SHALL have port cfg_valid_i, input, 1: configuration offer.
REQ-009 SHALL have port cfg_ready_o, output, 1: configuration accept.
REQ-010 SHALL have port lower_i, input, WIDTH+1, signed: lower wrap bound, inclusive.
REQ-011 SHALL have port upper_i, input, WIDTH+1, signed: upper wrap bound, inclusive.
REQ-012 SHALL have port data_valid_i, input, 1: data_i is qualified this cycle.
REQ-013 SHALL have port data_i, input, WIDTH, signed: phase increment.
REQ-014 SHALL have port phase_o, output, WIDTH+1, signed: wrapped phase, registered.
REQ-015 SHALL have port valid_o, output, 1: phase_o updated this cycle.
REQ-016 SHALL have port wrap_up_o, output, 1: one-cycle pulse on a wrap through the upper bound.
REQ-017 SHALL have port wrap_dn_o, output, 1: one-cycle pulse on a wrap through the lower bound.
REQ-018 SHALL have port wrap_cnt_o, output, CNT_WIDTH, signed: net wrap count (up minus down).
REQ-019 SHALL have port busy_o, output, 1: high in RUN.
REQ-020 SHALL have port err_o, output, 1: sticky error flag.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, ERR.
REQ-022 SHALL drive cfg_ready_o=1 only in IDLE; on cfg_valid_i & cfg_ready_o, register lower_q/upper_q.
REQ-023 SHALL, on an accepted config with upper_i <= lower_i, go to ERR and set err_o; registers unchanged.
REQ-024 SHALL, in IDLE with start_i and valid registered bounds (upper_q > lower_q), load phase_o=lower_q and wrap_cnt_o=0, then go to RUN.
REQ-025 SHALL, in RUN with data_valid_i, compute sum = phase_o + sign-extended data_i at WIDTH+2 bits; span = upper_q - lower_q + 1.
REQ-026 SHALL apply the wrap rule: sum > upper_q -> phase_o=sum-span, wrap_up_o=1, counter +1; sum < lower_q -> phase_o=sum+span, wrap_dn_o=1, counter -1; otherwise phase_o=sum.
REQ-027 SHALL, if the corrected value is still out of range (|data_i| >= span), clamp phase_o to the violated bound, set err_o sticky, stay in RUN, and still pulse the matching wrap output.
REQ-028 SHALL register phase_o, valid_o and the wrap pulses one cycle after the qualifying data_valid_i; valid_o=0 when data_valid_i=0 or when not in RUN.
REQ-029 SHALL saturate wrap_cnt_o at +2^(CNT_WIDTH-1)-1 and -2^(CNT_WIDTH-1); no roll-over.
REQ-030 SHALL, in RUN with clear_i, set phase_o=lower_q and wrap_cnt_o=0 next cycle; clear overrides concurrent data; valid_o=0 that cycle.
REQ-031 SHALL, in RUN with stop_i, return to IDLE and hold phase_o and wrap_cnt_o; stop overrides clear and data in the same cycle.
REQ-032 SHALL give stop_i priority over start_i when both are asserted in the same cycle; start_i in RUN is ignored.
REQ-033 SHALL leave ERR only via clear_i (-> IDLE, err_o cleared) or reset.

Reset
REQ-034 SHALL, on rst_i at any state including mid-RUN, next cycle set: IDLE; phase_o=0; wrap_cnt_o=0; valid_o, wrap_up_o, wrap_dn_o, busy_o, err_o all 0; lower_q=0; upper_q=2^WIDTH-1; cfg_ready_o=1.

Verification
REQ-035 SHALL cover: WIDTH=14, default bounds 0..16383, start, data +1000 until phase 16000 reached, then +1000 -> phase_o=616, wrap_up_o pulse, wrap_cnt_o=1.
REQ-036 SHALL cover: bounds -100..99, phase -90, data -20 -> phase_o=90, wrap_dn_o pulse, wrap_cnt_o=-1.
REQ-037 SHALL cover: config lower=50, upper=50 -> err_o=1, cfg_ready_o=0; clear_i -> IDLE, err_o=0.
REQ-038 SHALL cover: bounds 0..9, data +25 -> phase_o=9, err_o=1, FSM stays in RUN.
REQ-039 SHALL cover: start_i and stop_i together in IDLE -> no transition; stop_i, clear_i and data together in RUN -> IDLE, phase_o held.
REQ-040 SHALL cover: CNT_WIDTH=4, eight consecutive up-wraps -> wrap_cnt_o=7; then rst_i mid-RUN -> all outputs at reset values next cycle.
